// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM encodings and width helpers.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int unsigned GAP_W = 4;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Bit counter width: clog2 with a floor of one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned c;
    c = clog2(v);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// Load/shift register, bit counter and running even-parity accumulator for serial_tx.
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              next_bit_c,
  output logic              last_bit_c,
  output logic              parity
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);

  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  count;

  // sreg[0] mirrors the bit currently on the line; sreg[1] is the one to send next.
  generate
    if (DATA_W > 1) begin : g_multi
      assign next_bit_c = sreg[1];
    end else begin : g_single
      assign next_bit_c = 1'b0;
    end
  endgenerate

  assign last_bit_c = (count == CNT_W'(DATA_W - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg   <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sreg   <= din;
      count  <= '0;
      parity <= din[0];
    end else if (shift) begin
      sreg   <= sreg >> 1;
      count  <= count + CNT_W'(1);
      parity <= parity ^ next_bit_c;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: LSB-first payload, optional even parity, idle gap per frame.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              OUT,
  output logic              OUT_EN,
  output logic              BUSY,
  output logic              DONE
);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             load_c;
  logic             shift_c;
  logic             next_bit_c;
  logic             last_bit_c;
  logic             parity;

  assign DIN_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign load_c    = (state == ST_IDLE) && DIN_VALID;
  assign shift_c   = (state == ST_SHIFT) && !last_bit_c;

  serial_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load_c),
    .shift     (shift_c),
    .din       (DIN),
    .next_bit_c(next_bit_c),
    .last_bit_c(last_bit_c),
    .parity    (parity)
  );

  // Frame sequencer with registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      OUT     <= 1'b0;
      OUT_EN  <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (DIN_VALID) begin
            OUT    <= DIN[0];
            OUT_EN <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!last_bit_c) begin
            OUT <= next_bit_c;
          end else if (PARITY_EN != 0) begin
            OUT   <= parity;
            state <= ST_PARITY;
          end else if (GAP_CYC != 0) begin
            OUT     <= 1'b0;
            OUT_EN  <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            OUT    <= 1'b0;
            OUT_EN <= 1'b0;
            DONE   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_PARITY: begin
          OUT    <= 1'b0;
          OUT_EN <= 1'b0;
          if (GAP_CYC != 0) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
